// File: rtl/toggle_stimulus_gen_pkg.sv
// Shared state encoding, default parameters and a width helper for toggle_stimulus_gen.
package toggle_gen_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_PERIOD_W = 8;
  localparam int DEF_RUN_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Channel index width, never narrower than one bit so a single-channel build still has a port.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_stimulus_gen_if.sv
// Config write channel of toggle_stimulus_gen: valid/ready handshake carrying channel, half-period and initial level.
interface toggle_stimulus_gen_if
  import toggle_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PERIOD_W = DEF_PERIOD_W
);
  localparam int CHAN_W = chan_idx_w(CHANNELS);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHAN_W-1:0]   cfg_chan;
  logic [PERIOD_W-1:0] cfg_half;
  logic                cfg_init;

  modport master (output cfg_valid, cfg_chan, cfg_half, cfg_init, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_half, cfg_init, output cfg_ready);

endinterface

// File: rtl/toggle_stimulus_gen_chan.sv
// One generator channel: half-period counter, registered output level and a one-cycle toggle pulse.
module toggle_gen_chan #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] half,
  input  logic                init,
  output logic                level,
  output logic                toggled
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                toggled_q, toggled_d;

  // A zero half-period keeps the channel parked at its initial level.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    toggled_d = 1'b0;
    if (load) begin
      cnt_d   = '0;
      level_d = init;
    end else if (tick && (half != '0)) begin
      if (cnt_q == half - 1'b1) begin
        cnt_d     = '0;
        level_d   = ~level_q;
        toggled_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      toggled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      toggled_q <= toggled_d;
    end
  end

  assign level   = level_q;
  assign toggled = toggled_q;

endmodule

// File: rtl/toggle_stimulus_gen.sv
// Multi-channel square-wave generator: run FSM, per-channel config registers and optional run limit.
// Define TOGGLE_GEN_RUN_LIMIT_EN to enable run_len, the run counter and the DONE state.
module toggle_stimulus_gen
  import toggle_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int RUN_W    = DEF_RUN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  toggle_stimulus_gen_if.slave  cfg,
  input  logic                  start,
  input  logic                  stop,
  input  logic [RUN_W-1:0]      run_len,
  output logic                  busy,
  output logic                  done,
  output logic [CHANNELS-1:0]   chan_out,
  output logic [CHANNELS-1:0]   chan_edge
);
  state_e                            state_q, state_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] half_q, half_d;
  logic [CHANNELS-1:0]               init_q, init_d;
  logic                              cfg_hs;
  logic                              load;
  logic                              tick;

  assign cfg.cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign cfg_hs        = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = (state_q == RUN);

`ifdef TOGGLE_GEN_RUN_LIMIT_EN
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d, run_len_q, run_len_d, run_cnt_inc;
  logic             limit_hit;

  assign run_cnt_inc = run_cnt_q + 1'b1;
  assign limit_hit   = (run_len_q != '0) && (run_cnt_inc == run_len_q);
  assign done        = (state_q == DONE);
`else
  logic unused_run_len;

  assign unused_run_len = ^run_len;
  assign done           = 1'b0;
`endif

  // Writes to a channel index beyond the last channel complete the handshake but change nothing.
  always_comb begin
    half_d = half_q;
    init_d = init_q;
    if (cfg_hs && (int'(cfg.cfg_chan) < CHANNELS)) begin
      half_d[cfg.cfg_chan] = cfg.cfg_half;
      init_d[cfg.cfg_chan] = cfg.cfg_init;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    tick    = 1'b0;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start && !cfg.cfg_valid) begin
          state_d = RUN;
          load    = 1'b1;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
          run_cnt_d = '0;
          run_len_d = run_len;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
        end else if (limit_hit) begin
          state_d = DONE;
`endif
        end else begin
          tick = 1'b1;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
          run_cnt_d = run_cnt_inc;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      init_q  <= '0;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
      run_cnt_q <= '0;
      run_len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      init_q  <= init_d;
`ifdef TOGGLE_GEN_RUN_LIMIT_EN
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    toggle_gen_chan #(
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .tick    (tick),
      .half    (half_q[c]),
      .init    (init_q[c]),
      .level   (chan_out[c]),
      .toggled (chan_edge[c])
    );
  end

endmodule
